db_event_arbiter: RTL and testbench

DB_EVENT_ARBITER -- requirements
Module: db_event_arbiter

---
 rtl/db_event_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_db_event_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/db_event_arbiter.sv
// db_event_arbiter: per-channel switch debouncer sharing one tick divider,
// with one pending event slot per channel and a round-robin arbitrated,
// valid/ready event output register.
// Optional feature: define DB_INPUT_SYNC_EN to pass sw through a 2-flop
// synchronizer (adds 2 cycles of latency); otherwise sw must already be
// synchronous to clk.
module db_event_arbiter #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned TICK_DIV     = 200000,
  parameter int unsigned STABLE_TICKS = 10
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_CH-1:0]         sw,
  output logic [NUM_CH-1:0]         db,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [$clog2(NUM_CH)-1:0] evt_ch,
  output logic                      evt_press,
  output logic                      evt_ovf,
  input  logic                      ovf_clr
);

  localparam int unsigned CH_W = $clog2(NUM_CH);
  localparam int unsigned SM_W = CH_W + 1;
  localparam int unsigned TK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CT_W = $clog2(STABLE_TICKS + 1);

  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} state_e;

  logic [NUM_CH-1:0] sw_s;
  logic [TK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic              tick_c;
  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [CT_W-1:0]   tcnt_q [NUM_CH];
  logic [CT_W-1:0]   tcnt_d [NUM_CH];
  logic [NUM_CH-1:0] db_q, db_d;
  logic [NUM_CH-1:0] qual_c;
  logic [NUM_CH-1:0] pend_v_q, pend_v_d, pend_dir_q, pend_dir_d;
  logic              evt_valid_q, evt_valid_d;
  logic              evt_press_q, evt_press_d;
  logic              evt_ovf_q, evt_ovf_d;
  logic [CH_W-1:0]   evt_ch_q, evt_ch_d;
  logic [CH_W-1:0]   rr_q, rr_d;
  logic [CH_W-1:0]   win_c;
  logic [SM_W-1:0]   idx_c;
  logic              found_c, load_c, ovf_set_c;

`ifdef DB_INPUT_SYNC_EN
  logic [NUM_CH-1:0] sync1_q, sync2_q;

  // Two-flop synchronizer on the raw switch levels.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
    end
  end

  assign sw_s = sync2_q;
`else
  assign sw_s = sw;
`endif

  // Shared tick divider: one-cycle tick at TICK_DIV-1, then wrap.
  always_comb begin
    tick_c     = (tick_cnt_q == TK_W'(TICK_DIV - 1));
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TK_W'(1);
  end

  // Per-channel debounce FSM: next state, tick count, db and qualify pulse.
  always_comb begin
    db_d   = db_q;
    qual_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      state_d[i] = state_q[i];
      tcnt_d[i]  = tcnt_q[i];
      case (state_q[i])
        STABLE_LO, STABLE_HI: begin
          if (sw_s[i] != db_q[i]) begin
            state_d[i] = (state_q[i] == STABLE_LO) ? WAIT_HI : WAIT_LO;
            tcnt_d[i]  = '0;
          end
        end
        WAIT_HI, WAIT_LO: begin
          if (sw_s[i] == db_q[i]) begin
            state_d[i] = (state_q[i] == WAIT_HI) ? STABLE_LO : STABLE_HI;
          end else if (tick_c) begin
            tcnt_d[i] = tcnt_q[i] + CT_W'(1);
            if (tcnt_q[i] + CT_W'(1) == CT_W'(STABLE_TICKS)) begin
              state_d[i] = (state_q[i] == WAIT_HI) ? STABLE_HI : STABLE_LO;
              db_d[i]    = ~db_q[i];
              qual_c[i]  = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Round-robin search over full slots, starting at rr_q.
  always_comb begin
    found_c = 1'b0;
    win_c   = '0;
    idx_c   = '0;
    for (int n = 0; n < int'(NUM_CH); n++) begin
      idx_c = {1'b0, rr_q} + SM_W'(n);
      if (idx_c >= SM_W'(NUM_CH)) idx_c = idx_c - SM_W'(NUM_CH);
      if (!found_c && pend_v_q[idx_c[CH_W-1:0]]) begin
        found_c = 1'b1;
        win_c   = idx_c[CH_W-1:0];
      end
    end
  end

  // Output register load, slot clear/write and sticky overflow flag.
  always_comb begin
    pend_v_d    = pend_v_q;
    pend_dir_d  = pend_dir_q;
    evt_valid_d = evt_valid_q;
    evt_ch_d    = evt_ch_q;
    evt_press_d = evt_press_q;
    evt_ovf_d   = evt_ovf_q;
    rr_d        = rr_q;
    ovf_set_c   = 1'b0;
    load_c      = !evt_valid_q || evt_ready;
    if (load_c) begin
      evt_valid_d = found_c;
      if (found_c) begin
        evt_ch_d        = win_c;
        evt_press_d     = pend_dir_q[win_c];
        pend_v_d[win_c] = 1'b0;
        rr_d            = (win_c == CH_W'(NUM_CH - 1)) ? '0 : win_c + CH_W'(1);
      end
    end
    // A slot drained this cycle is free, so rewriting it is not an overflow.
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (qual_c[i]) begin
        if (pend_v_d[i]) ovf_set_c = 1'b1;
        pend_v_d[i]   = 1'b1;
        pend_dir_d[i] = db_d[i];
      end
    end
    if (ovf_set_c) evt_ovf_d = 1'b1;
    else if (ovf_clr) evt_ovf_d = 1'b0;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        state_q[i] <= STABLE_LO;
        tcnt_q[i]  <= '0;
      end
      db_q        <= '0;
      pend_v_q    <= '0;
      pend_dir_q  <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_press_q <= 1'b0;
      evt_ovf_q   <= 1'b0;
      rr_q        <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        state_q[i] <= state_d[i];
        tcnt_q[i]  <= tcnt_d[i];
      end
      db_q        <= db_d;
      pend_v_q    <= pend_v_d;
      pend_dir_q  <= pend_dir_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      evt_press_q <= evt_press_d;
      evt_ovf_q   <= evt_ovf_d;
      rr_q        <= rr_d;
    end
  end

  assign db        = db_q;
  assign evt_valid = evt_valid_q;
  assign evt_ch    = evt_ch_q;
  assign evt_press = evt_press_q;
  assign evt_ovf   = evt_ovf_q;

endmodule

// File: tb/tb_db_event_arbiter.sv
// Testbench for db_event_arbiter: directed scenarios plus random stimulus,
// every cycle compared against a behavioural reference model.
`timescale 1ns/1ps
module tb_db_event_arbiter;

  localparam int NCH = 4;
  localparam int TD  = 4;
  localparam int ST  = 3;
`ifdef DB_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic           clk;
  logic           reset;
  logic [NCH-1:0] sw;
  logic [NCH-1:0] db;
  logic           evt_valid;
  logic           evt_ready;
  logic [1:0]     evt_ch;
  logic           evt_press;
  logic           evt_ovf;
  logic           ovf_clr;

  db_event_arbiter #(
    .NUM_CH      (NCH),
    .TICK_DIV    (TD),
    .STABLE_TICKS(ST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .sw       (sw),
    .db       (db),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_ch   (evt_ch),
    .evt_press(evt_press),
    .evt_ovf  (evt_ovf),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;
  int log_q[$];

  // Reference model state.
  int             k_m;
  logic [NCH-1:0] db_m;
  bit             wait_m  [NCH];
  int             start_m [NCH];
  bit             pv_m    [NCH];
  bit             pd_m    [NCH];
  bit             v_m, p_m, ovf_m;
  int             ch_m, rr_m;
  logic [NCH-1:0] swh[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Number of ticks at edges a+1..b; ticks fall on edges e with e%TD==TD-1.
  function automatic int ticks_between(input int a, input int b);
    return (b + 1) / TD - (a + 1) / TD;
  endfunction

  function automatic int log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return -1;
  endfunction

  task automatic model_reset();
    k_m   = 0;
    db_m  = '0;
    v_m   = 1'b0;
    p_m   = 1'b0;
    ovf_m = 1'b0;
    ch_m  = 0;
    rr_m  = 0;
    for (int i = 0; i < NCH; i++) begin
      wait_m[i]  = 1'b0;
      start_m[i] = 0;
      pv_m[i]    = 1'b0;
      pd_m[i]    = 1'b0;
    end
    swh.delete();
  endtask

  task automatic model_edge(input logic rst, input logic [NCH-1:0] s_now,
                            input logic rdy, input logic clr);
    logic [NCH-1:0] s;
    bit             qual [NCH];
    int             got;
    int             c;
    bit             ovset;
    if (rst) begin
      model_reset();
    end else begin
      if (SYNC_LAT == 0) s = s_now;
      else if (swh.size() >= SYNC_LAT) s = swh[swh.size() - SYNC_LAT];
      else s = '0;
      swh.push_back(s_now);
      if (swh.size() > 8) void'(swh.pop_front());
      // Debounce: a change is accepted on the ST-th tick after it began.
      for (int i = 0; i < NCH; i++) begin
        qual[i] = 1'b0;
        if (!wait_m[i]) begin
          if (s[i] != db_m[i]) begin
            wait_m[i]  = 1'b1;
            start_m[i] = k_m;
          end
        end else if (s[i] == db_m[i]) begin
          wait_m[i] = 1'b0;
        end else if ((k_m % TD == TD - 1) && ticks_between(start_m[i], k_m) == ST) begin
          db_m[i]   = ~db_m[i];
          wait_m[i] = 1'b0;
          qual[i]   = 1'b1;
        end
      end
      // Output register takes the first full slot at or after rr_m.
      got = -1;
      if (!v_m || rdy) begin
        for (int n = 0; n < NCH; n++) begin
          c = (rr_m + n) % NCH;
          if (got < 0 && pv_m[c]) got = c;
        end
        v_m = (got >= 0);
        if (got >= 0) begin
          ch_m     = got;
          p_m      = pd_m[got];
          pv_m[got] = 1'b0;
          rr_m     = (got + 1) % NCH;
        end
      end
      ovset = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        if (qual[i]) begin
          if (pv_m[i]) ovset = 1'b1;
          pv_m[i] = 1'b1;
          pd_m[i] = db_m[i];
        end
      end
      if (ovset) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      k_m++;
    end
  endtask

  task automatic cycle();
    logic           rst_s, rdy_s, clr_s;
    logic [NCH-1:0] sw_s;
    rst_s = reset;
    sw_s  = sw;
    rdy_s = evt_ready;
    clr_s = ovf_clr;
    if (evt_valid && evt_ready && !reset) log_q.push_back(int'({evt_ch, evt_press}));
    @(posedge clk);
    model_edge(rst_s, sw_s, rdy_s, clr_s);
    #1;
    check_eq("db", 32'(db), 32'(db_m));
    check_eq("evt_valid", 32'(evt_valid), 32'(v_m));
    if (v_m) begin
      check_eq("evt_ch", 32'(evt_ch), 32'(ch_m));
      check_eq("evt_press", 32'(evt_press), 32'(p_m));
    end
    check_eq("evt_ovf", 32'(evt_ovf), 32'(ovf_m));
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    reset     = 1'b1;
    sw        = '0;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    model_reset();
    run(3);
    check_eq("reset_outputs", 32'({db, evt_valid, evt_ch, evt_press, evt_ovf}), 32'd0);
    reset = 1'b0;
    run(2);

    // Simultaneous ch0/ch3 press: ch0 then ch3.
    log_q.delete();
    sw = 4'b1001;
    run(20);
    check_eq("pair1_count", 32'(log_q.size()), 32'd2);
    check_eq("pair1_first", 32'(log_at(0)), 32'd1);
    check_eq("pair1_second", 32'(log_at(1)), 32'd7);

    // Single press on ch2.
    log_q.delete();
    sw[2] = 1'b1;
    run(20);
    check_eq("ch2_press_count", 32'(log_q.size()), 32'd1);
    check_eq("ch2_press_evt", 32'(log_at(0)), 32'd5);
    check_eq("ch2_db", 32'(db), 32'b1101);

    // Glitch on ch1 shorter than qualification: ignored.
    log_q.delete();
    sw[1] = 1'b1;
    run(8);
    sw[1] = 1'b0;
    run(15);
    check_eq("glitch_db", 32'(db[1]), 32'd0);
    check_eq("glitch_events", 32'(log_q.size()), 32'd0);

    // ch0/ch3 release pair after ch2 grant: ch3 first, then ch0.
    log_q.delete();
    sw[0] = 1'b0;
    sw[3] = 1'b0;
    run(20);
    check_eq("pair2_count", 32'(log_q.size()), 32'd2);
    check_eq("pair2_first", 32'(log_at(0)), 32'd6);
    check_eq("pair2_second", 32'(log_at(1)), 32'd0);

    // Consumer stalled: ch1 toggles twice, slot is overwritten.
    evt_ready = 1'b0;
    sw[1] = 1'b1; run(20);
    sw[1] = 1'b0; run(20);
    sw[1] = 1'b1; run(20);
    sw[1] = 1'b0; run(20);
    check_eq("stall_ovf", 32'(evt_ovf), 32'd1);
    check_eq("stall_valid", 32'(evt_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      run(1);
      check_eq("stall_hold_ch", 32'(evt_ch), 32'd1);
      check_eq("stall_hold_press", 32'(evt_press), 32'd1);
    end
    log_q.delete();
    evt_ready = 1'b1;
    run(3);
    check_eq("drain_count", 32'(log_q.size()), 32'd2);
    check_eq("drain_press", 32'(log_at(0)), 32'd3);
    check_eq("drain_release", 32'(log_at(1)), 32'd2);
    ovf_clr = 1'b1;
    run(1);
    ovf_clr = 1'b0;
    check_eq("ovf_cleared", 32'(evt_ovf), 32'd0);

    // Reset with an unaccepted event and ch3 mid-debounce.
    evt_ready = 1'b0;
    sw[0] = 1'b1;
    run(20);
    sw[3] = 1'b1;
    run(6);
    check_eq("pre_reset_valid", 32'(evt_valid), 32'd1);
    reset = 1'b1;
    run(1);
    reset = 1'b0;
    check_eq("post_reset_outputs", 32'({db, evt_valid, evt_ch, evt_press, evt_ovf}), 32'd0);
    log_q.delete();
    evt_ready = 1'b1;
    run(25);
    check_eq("reset_refire_count", 32'(log_q.size()), 32'd3);
    check_eq("reset_refire_0", 32'(log_at(0)), 32'd1);
    check_eq("reset_refire_1", 32'(log_at(1)), 32'd5);
    check_eq("reset_refire_2", 32'(log_at(2)), 32'd7);
    check_eq("reset_refire_db", 32'(db), 32'b1101);

    // Random phase against the reference model.
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < NCH; b++) begin
        if ($urandom_range(0, 11) == 0) sw[b] = ~sw[b];
      end
      evt_ready = ($urandom_range(0, 1) != 0);
      ovf_clr   = ($urandom_range(0, 19) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      cycle();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
